// File: rtl/mips_defs_pkg.sv
// ---------------------------------------------------------------------------
// mips_defs: shared MIPS decode constants for the ID decoder, the EX stage
// and the hazard unit.
//   - opcode (instr[31:26]) and funct (instr[5:0]) localparams
//   - alu_op_e : operation selected by the EX-stage ALU
//   - md_op_e  : operation issued to the multi-cycle mult/div unit
//   - md_decode: classifies an instruction as a mult/div issue (or none)
// ---------------------------------------------------------------------------
package mips_defs;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  // ALU_NOP drives a zero result for anything the ALU does not handle
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MFHI = 4'd12,
    ALU_MFLO = 4'd13,
    ALU_NOP  = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  // Classify an instruction as a mult/div issue; used by EX and the hazard unit
  function automatic md_op_e md_decode(input logic [31:0] instr);
    md_op_e op;
    op = MD_NONE;
    if (instr[31:26] == OP_RTYPE) begin
      case (instr[5:0])
        F_MULT:  op = MD_MULT;
        F_MULTU: op = MD_MULTU;
        F_DIV:   op = MD_DIV;
        F_DIVU:  op = MD_DIVU;
        default: op = MD_NONE;
      endcase
    end else begin
      op = MD_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit: architectural HI/LO registers plus the multi-cycle mult/div unit.
// The full 64-bit result is computed at issue and parked in a pending
// register; it is committed to HI/LO when the latency counter reaches zero.
// Ports:
//   clk, reset      clock / synchronous active-high reset
//   md_op           mult/div operation present in E (MD_NONE if none)
//   a, b            rs / rt operands
//   mthi, mtlo      move-to-HI/LO present in E
//   hi, lo          current HI/LO contents
//   busy            operation in flight (result not yet committed)
// ---------------------------------------------------------------------------
module md_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_e      md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]        hi_r, lo_r;
  logic [31:0]        pend_hi_r, pend_lo_r;
  logic               pend_wr_r;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               issue_s;
  logic signed [63:0] a_sx_s, b_sx_s;
  logic signed [63:0] sprod_s, squot_s, srem_s;
  logic [63:0]        uprod_s;
  logic [31:0]        res_hi_s, res_lo_s;
  logic               res_wr_s;
  logic [CNT_W-1:0]   cnt_load_s;

  // New operations are accepted only while idle
  assign issue_s = (md_op != MD_NONE) && !busy_r;

  // Result datapath and latency selection for the operation being issued
  always_comb begin
    a_sx_s     = {{32{a[31]}}, a};
    b_sx_s     = {{32{b[31]}}, b};
    sprod_s    = a_sx_s * b_sx_s;
    uprod_s    = {32'h0000_0000, a} * {32'h0000_0000, b};
    // 64-bit signed divide also yields the wrapped 0x80000000 for -2^31 / -1
    squot_s    = 64'sd0;
    srem_s     = 64'sd0;
    res_hi_s   = 32'h0000_0000;
    res_lo_s   = 32'h0000_0000;
    res_wr_s   = 1'b0;
    cnt_load_s = CNT_W'(MULT_CYCLES);
    case (md_op)
      MD_MULT: begin
        res_hi_s = sprod_s[63:32];
        res_lo_s = sprod_s[31:0];
        res_wr_s = 1'b1;
      end
      MD_MULTU: begin
        res_hi_s = uprod_s[63:32];
        res_lo_s = uprod_s[31:0];
        res_wr_s = 1'b1;
      end
      MD_DIV: begin
        cnt_load_s = CNT_W'(DIV_CYCLES);
        if (b != 32'h0000_0000) begin
          squot_s  = a_sx_s / b_sx_s;
          srem_s   = a_sx_s % b_sx_s;
          res_hi_s = srem_s[31:0];
          res_lo_s = squot_s[31:0];
          res_wr_s = 1'b1;
        end else begin
          // Divide by zero: full latency, but HI/LO are left untouched
          res_wr_s = 1'b0;
        end
      end
      MD_DIVU: begin
        cnt_load_s = CNT_W'(DIV_CYCLES);
        if (b != 32'h0000_0000) begin
          res_hi_s = a % b;
          res_lo_s = a / b;
          res_wr_s = 1'b1;
        end else begin
          res_wr_s = 1'b0;
        end
      end
      default: begin
        res_wr_s = 1'b0;
      end
    endcase
  end

  // Issue, countdown, completion write-back and mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r      <= 32'h0000_0000;
      lo_r      <= 32'h0000_0000;
      pend_hi_r <= 32'h0000_0000;
      pend_lo_r <= 32'h0000_0000;
      pend_wr_r <= 1'b0;
      busy_r    <= 1'b0;
      cnt_r     <= '0;
    end else begin
      if (issue_s) begin
        pend_hi_r <= res_hi_s;
        pend_lo_r <= res_lo_s;
        pend_wr_r <= res_wr_s;
        cnt_r     <= cnt_load_s;
        busy_r    <= 1'b1;
      end else if (cnt_r != '0) begin
        cnt_r <= cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          busy_r <= 1'b0;
          if (pend_wr_r) begin
            hi_r <= pend_hi_r;
            lo_r <= pend_lo_r;
          end
        end
      end
      // Moves are dropped while busy so the completion write wins
      if (!busy_r && mthi) begin
        hi_r <= a;
      end
      if (!busy_r && mtlo) begin
        lo_r <= a;
      end
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Decodes instr_E, computes the ALU result / effective address
// combinationally and hosts the HI/LO mult/div unit.
// Ports:
//   clk, reset     clock / synchronous active-high reset
//   instr_E        instruction in E (0 is a bubble)
//   srcA_E, srcB_E forwarded rs / rt operands
//   Imm32_lbit_E   ID-extended 16-bit immediate
//   Imm32_hbit_E   lui immediate (imm << 16)
//   ALUout_E       ALU result or effective address
//   Ov_E           signed overflow for add/addi/sub
//   md_start       mult/div present in E
//   md_busy        mult/div issuing or in flight (stall request to hazard unit)
// ---------------------------------------------------------------------------
module ex_stage
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_E,
  input  logic [31:0] srcA_E,
  input  logic [31:0] srcB_E,
  input  logic [31:0] Imm32_lbit_E,
  input  logic [31:0] Imm32_hbit_E,
  output logic [31:0] ALUout_E,
  output logic        Ov_E,
  output logic        md_start,
  output logic        md_busy
);

  logic [5:0]  opcode_s, funct_s;
  alu_op_e     alu_op_s;
  md_op_e      md_op_s;
  logic        use_imm_s, var_shift_s, ov_add_s, ov_sub_s;
  logic        mthi_s, mtlo_s;
  logic [31:0] opb_s, sum_s, diff_s, hi_s, lo_s;
  logic [4:0]  shamt_s;
  logic        busy_q_s;

  assign opcode_s = instr_E[31:26];
  assign funct_s  = instr_E[5:0];

  // Instruction decode into ALU operation and operand/overflow controls
  always_comb begin
    alu_op_s    = ALU_NOP;
    use_imm_s   = 1'b0;
    var_shift_s = 1'b0;
    ov_add_s    = 1'b0;
    ov_sub_s    = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          F_ADD:   begin alu_op_s = ALU_ADD; ov_add_s = 1'b1; end
          F_ADDU:  alu_op_s = ALU_ADD;
          F_SUB:   begin alu_op_s = ALU_SUB; ov_sub_s = 1'b1; end
          F_SUBU:  alu_op_s = ALU_SUB;
          F_AND:   alu_op_s = ALU_AND;
          F_OR:    alu_op_s = ALU_OR;
          F_XOR:   alu_op_s = ALU_XOR;
          F_NOR:   alu_op_s = ALU_NOR;
          F_SLT:   alu_op_s = ALU_SLT;
          F_SLTU:  alu_op_s = ALU_SLTU;
          F_SLL:   alu_op_s = ALU_SLL;
          F_SRL:   alu_op_s = ALU_SRL;
          F_SRA:   alu_op_s = ALU_SRA;
          F_SLLV:  begin alu_op_s = ALU_SLL; var_shift_s = 1'b1; end
          F_SRLV:  begin alu_op_s = ALU_SRL; var_shift_s = 1'b1; end
          F_SRAV:  begin alu_op_s = ALU_SRA; var_shift_s = 1'b1; end
          F_MFHI:  alu_op_s = ALU_MFHI;
          F_MFLO:  alu_op_s = ALU_MFLO;
          F_MTHI:  mthi_s = 1'b1;
          F_MTLO:  mtlo_s = 1'b1;
          default: alu_op_s = ALU_NOP;
        endcase
      end
      OP_ADDI:  begin alu_op_s = ALU_ADD; use_imm_s = 1'b1; ov_add_s = 1'b1; end
      OP_ADDIU, OP_LW, OP_SW, OP_LB, OP_SB: begin
        alu_op_s  = ALU_ADD;
        use_imm_s = 1'b1;
      end
      OP_ANDI:  begin alu_op_s = ALU_AND;  use_imm_s = 1'b1; end
      OP_ORI:   begin alu_op_s = ALU_OR;   use_imm_s = 1'b1; end
      OP_XORI:  begin alu_op_s = ALU_XOR;  use_imm_s = 1'b1; end
      OP_SLTI:  begin alu_op_s = ALU_SLT;  use_imm_s = 1'b1; end
      OP_SLTIU: begin alu_op_s = ALU_SLTU; use_imm_s = 1'b1; end
      OP_LUI:   alu_op_s = ALU_LUI;
      default:  alu_op_s = ALU_NOP;
    endcase
  end

  assign md_op_s  = md_decode(instr_E);
  assign md_start = (md_op_s != MD_NONE);

  assign opb_s   = use_imm_s ? Imm32_lbit_E : srcB_E;
  assign shamt_s = var_shift_s ? srcA_E[4:0] : instr_E[10:6];
  assign sum_s   = srcA_E + opb_s;
  assign diff_s  = srcA_E - opb_s;

  // ALU result mux
  always_comb begin
    ALUout_E = 32'h0000_0000;
    case (alu_op_s)
      ALU_ADD:  ALUout_E = sum_s;
      ALU_SUB:  ALUout_E = diff_s;
      ALU_AND:  ALUout_E = srcA_E & opb_s;
      ALU_OR:   ALUout_E = srcA_E | opb_s;
      ALU_XOR:  ALUout_E = srcA_E ^ opb_s;
      ALU_NOR:  ALUout_E = ~(srcA_E | opb_s);
      ALU_SLT:  ALUout_E = {31'h0000_0000, ($signed(srcA_E) < $signed(opb_s))};
      ALU_SLTU: ALUout_E = {31'h0000_0000, (srcA_E < opb_s)};
      ALU_SLL:  ALUout_E = srcB_E << shamt_s;
      ALU_SRL:  ALUout_E = srcB_E >> shamt_s;
      ALU_SRA:  ALUout_E = $signed(srcB_E) >>> shamt_s;
      ALU_LUI:  ALUout_E = Imm32_hbit_E;
      ALU_MFHI: ALUout_E = hi_s;
      ALU_MFLO: ALUout_E = lo_s;
      default:  ALUout_E = 32'h0000_0000;
    endcase
  end

  // Signed overflow: add needs equal operand signs, sub needs differing signs
  always_comb begin
    if (ov_add_s) begin
      Ov_E = (srcA_E[31] == opb_s[31]) && (sum_s[31] != srcA_E[31]);
    end else if (ov_sub_s) begin
      Ov_E = (srcA_E[31] != opb_s[31]) && (diff_s[31] != srcA_E[31]);
    end else begin
      Ov_E = 1'b0;
    end
  end

  md_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_unit (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op_s),
    .a     (srcA_E),
    .b     (srcB_E),
    .mthi  (mthi_s),
    .mtlo  (mtlo_s),
    .hi    (hi_s),
    .lo    (lo_s),
    .busy  (busy_q_s)
  );

  assign md_busy = md_start | busy_q_s;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Decodes instr_E and computes the ALU result (arithmetic, logic, shift, compare, lui, mfhi/mflo) combinationally.
- Owns the architectural HI/LO registers and a multi-cycle mult/div unit.
- Exposes md_busy so the hazard unit can stall dependent instructions in D.

Parameters:
MULT_CYCLES, 5, cycles HI/LO stay pending after a mult/multu issues (>=1)
DIV_CYCLES, 10, cycles HI/LO stay pending after a div/divu issues (>=1)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears HI, LO, counter, pending result
instr_E  input  32  instruction in E (0 = bubble, sll $0,$0,0)
srcA_E  input  32  forwarded rs operand (forwarding mux is external)
srcB_E  input  32  forwarded rt operand
Imm32_lbit_E  input  32  immediate extended by ID (sign for addi/addiu/slti/sltiu/lw/sw; zero for andi/ori/xori)
Imm32_hbit_E  input  32  lui immediate (imm<<16)
ALUout_E  output  32  combinational result / effective address
Ov_E  output  1  signed overflow on add/addi/sub; 0 otherwise
md_start  output  1  combinational; 1 when instr_E is mult/multu/div/divu
md_busy  output  1  md_start | busy_q; hazard unit stalls D-stage mult/div/mf/mt when high

Behaviour:
- Clock and reset: one clock clk; reset is synchronous, active-high, sampled on posedge clk only.
- Reset state: HI=0, LO=0, busy_q=0, counter=0, pending=0.
  - After reset instr_E=0, so ALUout_E=0, Ov_E=0, md_start=0, md_busy=0.
- ALU, R-type by funct:
  - addu/add 0x21/0x20: A+B.
  - subu/sub 0x23/0x22: A-B.
  - and/or/xor/nor 0x24-0x27: bitwise ops.
  - slt 0x2a: signed A<B, result {31'b0,bit}.
  - sltu 0x2b: unsigned A<B, same result format.
  - sll/srl/sra 0x00/0x02/0x03: shift B by instr[10:6].
  - sllv/srlv/srav 0x04/0x06/0x07: shift B by A[4:0].
  - mfhi 0x10: HI. mflo 0x12: LO.
- ALU, I-type by opcode:
  - addi/addiu 0x08/0x09, lw/sw/lb/sb 0x23/0x2b/0x20/0x28: A+Imm32_lbit.
  - andi/ori/xori 0x0c/0x0d/0x0e: bitwise with Imm32_lbit.
  - slti/sltiu 0x0a/0x0b: compare against Imm32_lbit.
  - lui 0x0f: Imm32_hbit.
- Any other instruction: ALUout_E = 0.
- Ov_E: operand signs equal and result sign differs (sub uses the negated-B rule). Wrap-around result is still driven; trapping is not this block's job.
- mult/div issue (posedge with md_start=1 and busy_q=0):
  - Compute the 64-bit result into pending: mult/multu → {HI,LO}=A*B; div/divu → LO=quotient, HI=remainder. Signed ops truncate toward zero; remainder takes the dividend's sign.
  - Load counter = MULT_CYCLES or DIV_CYCLES; busy_q=1.
- Countdown: each posedge with counter>0, counter decrements. On the edge where counter goes 1→0, HI/LO get pending and busy_q=0.
  - busy_q is high for exactly N cycles after the issue edge; mfhi issued N+1 cycles after mult sees the new value.
- Divide by zero (B=0, div/divu): full DIV_CYCLES latency; HI/LO unchanged at completion.
- mthi 0x11 / mtlo 0x13 in E with busy_q=0: HI/LO = A on the posedge.
- md_start while busy_q=1: ignored; the hazard unit guarantees this cannot occur.
- mthi/mtlo while busy_q=1: ignored; completion write has priority.
- Reset mid-operation: the operation is aborted; state returns to reset values on that edge.
- Bubbles: ID/EX clr yields instr_E=0, which is a no-op; an in-flight md operation continues.

Decomposition:
- Package mips_defs: opcode and funct localparams, ALU-op enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO), md-op enum. Shared with the ID decoder and hazard unit.
- One sub-module, md_unit: HI/LO, counter, pending, busy. ALU and decode stay in ex_stage.

Test Plan:
- reset held 2 cycles, instr_E=0 → ALUout_E=0, md_busy=0; a following mfhi/mflo return 0.
- addu A=0xFFFFFFFF, B=1 → ALUout_E=0, Ov_E=0. add A=0x7FFFFFFF, B=1 → ALUout_E=0x80000000, Ov_E=1.
- sra B=0x80000000 shamt=4 → 0xF8000000. slt A=-1,B=1 → 1; sltu same operands → 0. lui imm 0x1234 → 0x12340000.
- mult A=-3, B=7 then bubbles:
  - md_busy high for 6 cycles (start + 5 busy).
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB after completion edge.
  - mfhi/mflo return those values.
- div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. divu B=0 with HI=5, LO=9 beforehand → HI/LO stay 5/9.
- Reset asserted on busy cycle 3 of a div → busy=0 next cycle, HI=LO=0; no late write-back. mthi A=0xAA with busy=0 → HI=0xAA.
